// File: rtl/sq_arb_pkg.sv
// Shared constants, FSM encoding and helpers for the square-LUT arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sq_arb_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int SQ_W_DEF  = 16;
    localparam int CNT_W     = 16;
    localparam int MAX_REQ   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Sized for the widest supported requester count; callers truncate.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] id);
        onehot     = '0;
        onehot[id] = 1'b1;
    endfunction

endpackage

// File: rtl/sq_lut_arbiter_rr_arbiter.sv
// Rotating-priority arbiter: grants the first valid request at or after rr_ptr.
// Latency: grant is combinational; the pointer advances past the grantee at the clock edge.
// Backpressure: en=0 suppresses every grant and freezes the pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_any
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] rr_ptr;

    always_comb begin
        int              j;
        logic [ID_W-1:0] idx;
        j         = 0;
        idx       = '0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        if (en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                j   = (int'(rr_ptr) + k) % NUM_REQ;
                idx = ID_W'(j);
                if (!grant_any && req[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = idx;
                end
            end
            if (grant_any) begin
                grant[grant_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/sq_lut_arbiter.sv
// Shares one registered square LUT among NUM_REQ requesters; optional per-requester grant counters under SQ_ARB_STATS_EN.
// Latency: request accepted in cycle T, squared result returned to that requester in T+1; one lookup per cycle.
// Backpressure: req_ready is a one-hot round-robin grant; responses cannot be stalled and must be sunk.
module sq_lut_arbiter
    import sq_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PIX_W   = PIX_W_DEF,
    parameter int SQ_W    = SQ_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*PIX_W-1:0]   req_pixel,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       lut_work,
    output logic [PIX_W-1:0]           lut_pixel,
    input  logic [SQ_W-1:0]            lut_square,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [SQ_W-1:0]            rsp_square,
`ifdef SQ_ARB_STATS_EN
    input  logic                       stat_clr,
    output logic [NUM_REQ*CNT_W-1:0]   stat_grant_cnt,
`endif
    output logic                       busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_t          state;
    state_t          state_nxt;
    logic            inflight;
    logic [ID_W-1:0] inflight_id;
    logic            arb_en;
    logic            any_valid;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0] grant_idx;
    logic            grant_any;

    assign any_valid = |req_valid;
    // Gating with rst_n keeps the combinational outputs at zero while reset is held.
    assign arb_en    = en && rst_n && (state != ST_DRAIN);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (arb_en),
        .req       (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = grant;
    assign lut_work  = grant_any;

    always_comb begin
        lut_pixel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                lut_pixel = req_pixel[i*PIX_W +: PIX_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight    <= 1'b0;
            inflight_id <= '0;
            state       <= ST_IDLE;
        end else begin
            inflight <= grant_any;
            if (grant_any) begin
                inflight_id <= grant_idx;
            end
            state <= state_nxt;
        end
    end

    assign rsp_valid  = inflight ? NUM_REQ'(onehot(3'(inflight_id))) : '0;
    assign rsp_id     = inflight_id;
    assign rsp_square = inflight ? lut_square : '0;

    always_comb begin
        state_nxt = state;
        busy      = inflight || (en && rst_n && any_valid);
        case (state)
            ST_IDLE: begin
                if (en && any_valid) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en && inflight) begin
                    state_nxt = ST_DRAIN;
                end else if (!inflight && !(en && any_valid)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                busy      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef SQ_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (stat_clr) begin
                cnt <= '0;
            end else if (grant[i] && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end
        assign stat_grant_cnt[i*CNT_W +: CNT_W] = cnt;
    end
`endif

endmodule
